// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory controller: state encoding,
// write/read opcodes and the mask/address alignment rule for stores.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  localparam logic WE_WRITE  = 1'b1;
  localparam logic WE_READ   = 1'b0;
  localparam int   WORD_BITS = 32;
  localparam int   MASK_W    = WORD_BITS / 8;

  // A half-word store must sit on an even byte, a full-word store on a word boundary.
  function automatic logic write_misaligned(input logic [MASK_W-1:0] mask,
                                            input logic [1:0]        addr_lo);
    logic half;
    logic full;
    half = ((mask == 4'b0011) || (mask == 4'b1100)) && addr_lo[0];
    full = (mask == 4'b1111) && (addr_lo != 2'b00);
    return half || full;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core's memory stage (master) and the
// data-memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32
);
    logic                    request;
    logic                    we_re;
    logic [DATA_WIDTH/8-1:0] mask;
    logic [ADDRESS-1:0]      address;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    valid;
    logic                    busy;
    logic                    err;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, busy, err
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, busy, err
    );
endinterface

// File: rtl/sram_bytewise.sv
// Word-addressed SRAM with per-byte write enables and a registered read port
// that can be cleared, so the controller can return zero on a faulted access.
module sram_bytewise #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int BYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      addr,
    input  logic [BYTES-1:0]      byte_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array deliberately has no reset; only the read register does.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (byte_we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: request/response FSM with WAIT_STATES extra access
// cycles, range/alignment checking, and a single byte-maskable SRAM.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDRESS     = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic           clk,
    input logic           rst,
    data_mem_ctrl_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         BYTES    = DATA_WIDTH / 8;
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [2:0]            cnt;
    logic                  err_q;

    logic                  lat_we;
    logic [BYTES-1:0]      lat_mask;
    logic [ADDRESS-1:0]    lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  cmd_we;
    logic [BYTES-1:0]      cmd_mask;
    logic [ADDRESS-1:0]    cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  cmd_oor;
    logic                  cmd_err;
    logic                  accept;
    logic                  commit;

    logic [BYTES-1:0]      sram_byte_we;
    logic                  sram_rd_en;
    logic                  sram_rd_clr;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // With zero wait states the array is accessed on the accepting edge, so the
    // live bus fields are used in IDLE and the latched copy otherwise.
    assign cmd_we    = (state == S_IDLE) ? bus.we_re      : lat_we;
    assign cmd_mask  = (state == S_IDLE) ? bus.mask       : lat_mask;
    assign cmd_addr  = (state == S_IDLE) ? bus.address    : lat_addr;
    assign cmd_wdata = (state == S_IDLE) ? bus.store_data : lat_wdata;

    assign cmd_oor = |cmd_addr[ADDRESS-1:IDX_W+2];
    assign cmd_err = cmd_oor ||
                     ((cmd_we == WE_WRITE) && write_misaligned(cmd_mask, cmd_addr[1:0]));

    assign accept = (state == S_IDLE) && bus.request;
    assign commit = !rst && ((accept && NO_WAIT) || ((state == S_ACCESS) && (cnt == 3'd0)));

    assign sram_byte_we = (commit && (cmd_we == WE_WRITE) && !cmd_err) ? cmd_mask : '0;
    assign sram_rd_en   = commit && (cmd_we == WE_READ) && !cmd_err;
    assign sram_rd_clr  = commit && cmd_err;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.request) state_nxt = NO_WAIT ? S_RESP : S_ACCESS;
            S_ACCESS: if (cnt == 3'd0) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            err_q     <= 1'b0;
            lat_we    <= WE_READ;
            lat_mask  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we    <= bus.we_re;
                lat_mask  <= bus.mask;
                lat_addr  <= bus.address;
                lat_wdata <= bus.store_data;
                cnt       <= CNT_INIT;
            end else if ((state == S_ACCESS) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (commit) begin
                err_q <= cmd_err;
            end
        end
    end

    sram_bytewise #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .addr    (cmd_addr[IDX_W+1:2]),
        .byte_we (sram_byte_we),
        .wdata   (cmd_wdata),
        .rd_en   (sram_rd_en),
        .rd_clr  (sram_rd_clr),
        .rdata   (sram_rdata)
    );

    assign bus.valid     = (state == S_RESP);
    assign bus.busy      = (state == S_ACCESS) || (state == S_RESP);
    assign bus.err       = err_q;
    assign bus.load_data = sram_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with one wait state, one with none,
// both checked against a word-array model of the memory and its error rules.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mdl [int];
    logic [31:0] last_ld [2];

    data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) bus1 ();
    data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDRESS(32)) bus0 ();

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(1024), .WAIT_STATES(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );
    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus1.request = req; bus1.we_re = we; bus1.mask = m; bus1.address = a; bus1.store_data = d;
        end else begin
            bus0.request = req; bus0.we_re = we; bus0.mask = m; bus0.address = a; bus0.store_data = d;
        end
    endtask

    task automatic sample(input bit sel, output logic v, output logic b, output logic e,
                          output logic [31:0] ld);
        if (sel) begin
            v = bus1.valid; b = bus1.busy; e = bus1.err; ld = bus1.load_data;
        end else begin
            v = bus0.valid; b = bus0.busy; e = bus0.err; ld = bus0.load_data;
        end
    endtask

    // One complete transaction; expectations come from the memory model and the error rules.
    task automatic do_op(input bit sel, input logic we, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, input string tag, output logic [31:0] ld_seen);
        logic        exp_e;
        logic [31:0] exp_ld;
        int          key;
        int          lat;
        bit          got;
        logic        v, b, e;
        logic [31:0] ld;
        key   = (sel ? 4096 : 0) + int'(a[11:2]);
        exp_e = (a >= 32'h1000) ||
                (we && ((((m == 4'b0011) || (m == 4'b1100)) && a[0]) ||
                        ((m == 4'b1111) && (a[1:0] != 2'b00))));
        if (exp_e)    exp_ld = 32'h0;
        else if (!we) exp_ld = mdl.exists(key) ? mdl[key] : 32'h0;
        else          exp_ld = last_ld[sel];

        @(negedge clk);
        drive(sel, 1'b1, we, m, a, d);
        got = 0; lat = 0; ld = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            sample(sel, v, b, e, ld);
            if (v) begin
                got = 1; lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), sel ? 32'd2 : 32'd1);
        if (got) begin
            check({tag, " err"}, {31'b0, e}, {31'b0, exp_e});
            check({tag, " load_data"}, ld, exp_ld);
            check({tag, " busy"}, {31'b0, b}, 32'd1);
        end
        ld_seen = ld;
        drive(sel, 1'b0, we, m, a, d);
        @(posedge clk); #1;
        sample(sel, v, b, e, ld);
        check({tag, " valid gap"}, {31'b0, v}, 32'd0);

        if (we && !exp_e) begin
            logic [31:0] w;
            w = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int k = 0; k < 4; k++) if (m[k]) w[8*k +: 8] = d[8*k +: 8];
            mdl[key] = w;
        end
        last_ld[sel] = exp_ld;
    endtask

    initial begin
        logic        v, b, e;
        logic [31:0] ld;
        logic [31:0] a, d;
        logic [3:0]  m;
        logic        we;

        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        last_ld[0] = 32'h0;
        last_ld[1] = 32'h0;

        #12;
        sample(1'b1, v, b, e, ld);
        check("reset valid", {31'b0, v}, 32'd0);
        check("reset busy", {31'b0, b}, 32'd0);
        check("reset err", {31'b0, e}, 32'd0);
        check("reset load_data", ld, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full-word write then read back.
        do_op(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr 0x10", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd 0x10", ld);
        check("rd 0x10 const", ld, 32'hDEADBEEF);

        // Async reset while a write to the same word is in ACCESS.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678);
        @(posedge clk); #1;
        sample(1'b1, v, b, e, ld);
        check("pre-reset busy", {31'b0, b}, 32'd1);
        rst = 1'b1;
        #1;
        sample(1'b1, v, b, e, ld);
        check("mid reset valid", {31'b0, v}, 32'd0);
        check("mid reset busy", {31'b0, b}, 32'd0);
        check("mid reset err", {31'b0, e}, 32'd0);
        check("mid reset load_data", ld, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_ld[0] = 32'h0;
        last_ld[1] = 32'h0;
        @(posedge clk); #1;
        sample(1'b1, v, b, e, ld);
        check("post reset busy", {31'b0, b}, 32'd0);
        do_op(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd after abort", ld);

        // Byte-masked update.
        do_op(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, "wr 0x20", ld);
        do_op(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, "wr byte1", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, "rd masked", ld);
        check("masked const", ld, 32'h1122AA44);
        do_op(1'b1, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, "wr mask0", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, "rd after mask0", ld);

        // Out of range.
        do_op(1'b1, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, "wr word0", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, "rd oor", ld);
        do_op(1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFF0000, "wr oor", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, "rd word0", ld);
        check("word0 const", ld, 32'h0BADF00D);

        // Misaligned stores and an unaligned load.
        do_op(1'b1, 1'b1, 4'hF, 32'h22, 32'h55555555, "wr mis full", ld);
        do_op(1'b1, 1'b1, 4'b0011, 32'h21, 32'h66666666, "wr mis half", ld);
        do_op(1'b1, 1'b0, 4'h0, 32'h22, 32'h0, "rd 0x22", ld);
        check("0x22 const", ld, 32'h1122AA44);

        // Zero wait states: back-to-back reads with request held high.
        do_op(1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, "ws0 wr", ld);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            sample(1'b0, v, b, e, ld);
            check("b2b valid", {31'b0, v}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check("b2b load_data", ld, 32'hCAFEF00D);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        last_ld[0] = 32'hCAFEF00D;

        // Randomized traffic on both instances over a small initialized window.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(s[0], 1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom, "rnd init", ld);
            end
            for (int n = 0; n < 60; n++) begin
                a  = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 32'h7FFF));
                we = 1'($urandom_range(0, 1));
                m  = 4'($urandom_range(0, 15));
                d  = $urandom;
                do_op(s[0], we, m, a, d, "rnd", ld);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
